// File: rtl/led_blink_pkg.sv
// Shared types for the LED blink controller: channel mode encoding and the
// LED value a channel presents immediately after it is (re)configured.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  localparam int unsigned CH_W = 5;

  // All counters restart at zero on a write, so the first LED value is
  // known from mode and duty alone (PWM: phase 0 < duty).
  function automatic logic led_on_write(mode_t m, logic duty_nz);
    return (m == MODE_ON) || ((m == MODE_PWM) && duty_nz);
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration write port of the LED blink controller.
interface led_blink_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PWM_W = 8
);
  import led_blink_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  mode_t            cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [PWM_W-1:0] cfg_duty;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: stored mode/period/duty, blink counter, PWM phase and
// the registered LED bit. A write overrides any tick arriving on the same edge.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_wr,
  input  mode_t            i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_led
);

  mode_t            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [PWM_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_phase;
  logic             r_led;

  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PWM_W-1:0] w_phase_nxt;
  logic             w_led_nxt;

  // Period 0 is treated as period 1: toggle on every tick.
  assign w_last = (r_period == '0) ? '0 : r_period - CNT_W'(1);

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_led_nxt   = r_led;
    unique case (r_mode)
      MODE_OFF: w_led_nxt = 1'b0;
      MODE_ON:  w_led_nxt = 1'b1;
      MODE_BLINK: begin
        if (i_tick) begin
          if (r_cnt == w_last) begin
            w_cnt_nxt = '0;
            w_led_nxt = ~r_led;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      MODE_PWM: begin
        if (i_tick) w_phase_nxt = r_phase + PWM_W'(1);
        w_led_nxt = (w_phase_nxt < r_duty);
      end
      default: w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_OFF;
      r_period <= '0;
      r_duty   <= '0;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_led    <= 1'b0;
    end else if (i_wr) begin
      r_mode   <= i_mode;
      r_period <= i_period;
      r_duty   <= i_duty;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_led    <= led_on_write(i_mode, i_duty != '0);
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
      r_led    <= w_led_nxt;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_blink_ctrl.sv
// LED blink controller top: free-running prescaler tick, configuration
// decode with out-of-range error pulse, and N_LED independent channels.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESCALE = 100000
) (
  input  logic             clk,
  input  logic             rst,
  led_blink_ctrl_if.slave  cfg,
  output logic [N_LED-1:0] led
);

  localparam int unsigned        PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               r_err;
  logic               w_tick;
  logic               w_accept;
  logic               w_ch_ok;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  assign cfg.cfg_ready = ~rst;
  assign w_accept      = cfg.cfg_valid & cfg.cfg_ready;
  // Extra bit so N_LED = 32 still compares correctly against a 5-bit index.
  assign w_ch_ok       = ({1'b0, cfg.cfg_ch} < 6'(N_LED));

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_accept & ~w_ch_ok;
  end

  assign cfg.cfg_err = r_err;

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    logic w_wr;
    logic w_led;

    assign w_wr = w_accept && w_ch_ok && (cfg.cfg_ch == CH_W'(g));

    led_blink_chan #(
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_wr     (w_wr),
      .i_mode   (cfg.cfg_mode),
      .i_period (cfg.cfg_period),
      .i_duty   (cfg.cfg_duty),
      .o_led    (w_led)
    );

    assign led[g] = w_led;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed and randomized bench for led_blink_ctrl against a tick-count
// reference model (LED value derived from ticks elapsed since the last write).
module tb_led_blink_ctrl;
  import led_blink_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] led;

  led_blink_ctrl_if #(.CNT_W(CW), .PWM_W(PW)) cfg_if ();

  led_blink_ctrl #(
    .N_LED    (N),
    .CNT_W    (CW),
    .PWM_W    (PW),
    .PRESCALE (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cfg (cfg_if),
    .led (led)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mode_t           m_mode   [N];
  int unsigned     m_period [N];
  int unsigned     m_duty   [N];
  longint unsigned m_t      [N];
  longint unsigned m_edges;
  logic            m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0]    v;
    longint unsigned p;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (m_mode[i])
        MODE_ON:    v[i] = 1'b1;
        MODE_BLINK: begin
          p    = (m_period[i] == 0) ? 1 : m_period[i];
          v[i] = ((m_t[i] / p) % 2) == 1;
        end
        MODE_PWM:   v[i] = (m_t[i] % (1 << PW)) < m_duty[i];
        default:    v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // One clock edge: advance the model from the inputs the DUT sees, then check.
  task automatic cycle();
    logic tick;
    @(posedge clk);
    if (rst) begin
      m_edges = 0;
      m_err   = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = MODE_OFF; m_period[i] = 0; m_duty[i] = 0; m_t[i] = 0;
      end
    end else begin
      tick    = (m_edges % P) == (P - 1);
      m_edges = m_edges + 1;
      m_err   = cfg_if.cfg_valid && (cfg_if.cfg_ch >= N);
      for (int i = 0; i < N; i++) begin
        if (cfg_if.cfg_valid && (cfg_if.cfg_ch == i)) begin
          m_mode[i]   = cfg_if.cfg_mode;
          m_period[i] = cfg_if.cfg_period;
          m_duty[i]   = cfg_if.cfg_duty;
          m_t[i]      = 0;
        end else if (tick) begin
          m_t[i] = m_t[i] + 1;
        end
      end
    end
    #1;
    check("led", 32'(led), 32'(exp_led()));
    check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!rst));
  endtask

  task automatic wr(input int unsigned ch, input mode_t mode,
                    input int unsigned period, input int unsigned duty);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 5'(ch);
    cfg_if.cfg_mode   = mode;
    cfg_if.cfg_period = 16'(period);
    cfg_if.cfg_duty   = 8'(duty);
    cycle();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    int unsigned hi_cnt;
    logic        found;
    int unsigned d;

    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_mode   = MODE_OFF;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;

    // Reset held three edges, then release
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // ON, BLINK, PWM on separate channels
    wr(0, MODE_ON, 0, 0);
    check("ch0_on", 32'(led[0]), 32'd1);
    repeat (5) cycle();
    wr(1, MODE_BLINK, 3, 0);
    repeat (60) cycle();
    wr(2, MODE_PWM, 0, 64);
    hi_cnt = 0;
    for (int k = 0; k < 1024; k++) begin
      cycle();
      if (led[2]) hi_cnt++;
    end
    check("pwm64_high_cycles", hi_cnt, 32'd256);

    // Out-of-range channel, then cfg_err must drop again
    wr(5, MODE_ON, 7, 9);
    check("err_pulse", 32'(cfg_if.cfg_err), 32'd1);
    cycle();
    check("err_one_cycle", 32'(cfg_if.cfg_err), 32'd0);

    // Boundary duties and zero period
    wr(3, MODE_PWM, 0, 255);
    repeat (1030) cycle();
    wr(3, MODE_PWM, 0, 0);
    repeat (20) cycle();
    wr(3, MODE_BLINK, 0, 0);
    repeat (20) cycle();

    // Reset while ch1 is lit, with a write pending that must be discarded
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (led[1]) found = 1'b1;
    end
    check("blink_reached_high", 32'(found), 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 5'd1;
    cfg_if.cfg_mode  = MODE_ON;
    rst = 1'b1;
    cycle();
    check("led_after_rst", 32'(led), 32'd0);
    cfg_if.cfg_valid = 1'b0;
    rst = 1'b0;
    repeat (30) cycle();
    check("ch1_stays_off", 32'(led[1]), 32'd0);

    // Randomized writes, including invalid channels and same-edge tick/write
    for (int k = 0; k < 600; k++) begin
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch     = 5'($urandom_range(0, 7));
      cfg_if.cfg_mode   = mode_t'($urandom_range(0, 3));
      cfg_if.cfg_period = 16'($urandom_range(0, 4));
      d = $urandom_range(0, 3);
      cfg_if.cfg_duty   = (d == 0) ? 8'd0 : (d == 1) ? 8'd255 : 8'($urandom_range(1, 254));
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
